scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
Sequences a scan chain of DFF cells in the standard-cell library. Each test runs in four steps:
- serially loads a test pattern into the chain,
- pulses one capture cycle,
- shifts the response back out,
- compares the response against an expected word.
It sits between a test-vector source and a mapped netlist whose DFFs have a scan-enable mux on D. It is the controller that makes the mapped flops testable after synthesis.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (N ≥ 1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the internal shift counter.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, synchronous, active-low.
- START  input  1  request a test run; sampled only in IDLE.
- PAT  input  CHAIN_LEN  pattern to load; latched on accepted START.
- EXP  input  CHAIN_LEN  expected response; latched on accepted START.
- SO  input  1  scan-out bit from the last chain stage.
- SE  output  1  scan enable to the chain muxes (1 = shift, 0 = functional D).
- SI  output  1  scan-in bit to chain stage 0.
- CAP  output  1  capture-cycle strobe; high for exactly one cycle.
- BUSY  output  1  high from the cycle after START is accepted through the DONE cycle.
- DONE  output  1  one-cycle pulse; RESP and MISMATCH are valid from this cycle.
- RESP  output  CHAIN_LEN  captured response.
- MISMATCH  output  1  RESP != latched EXP; updated in the DONE cycle.

Behaviour:
- Clock is C. Reset is synchronous, active-low on RN. No asynchronous paths.
- Reset (RN=0 at an edge), including mid-run:
  - state goes to IDLE;
  - SE, SI, CAP, BUSY, DONE, MISMATCH = 0;
  - RESP = 0; counter = 0; latched PAT and EXP = 0.
- States: IDLE → SHIFT_IN → CAPTURE → SHIFT_OUT → FIN → IDLE.
- IDLE:
  - all strobes are 0.
  - START=1 at an edge latches PAT and EXP, loads counter = N-1, and moves to SHIFT_IN.
- SHIFT_IN, exactly N cycles:
  - SE=1.
  - SI = latched PAT, MSB first: cycle i drives PAT[N-1-i].
  - Counter decrements; the last cycle is counter==0, then move to CAPTURE.
- CAPTURE, 1 cycle:
  - SE=0, CAP=1, SI=0.
  - Reload counter = N-1 and move to SHIFT_OUT.
- SHIFT_OUT, exactly N cycles:
  - SE=1, SI=0.
  - Each edge does RESP <= {RESP[N-2:0], SO}, so the first bit out ends in RESP[N-1]. For N=1, RESP <= SO.
  - Move to FIN after the counter==0 cycle.
- FIN, 1 cycle:
  - DONE=1, SE=0.
  - MISMATCH is registered as (RESP != EXP_latched) using the final RESP. It is registered on entry to FIN so it is valid in the same cycle as DONE.
  - Next state is IDLE.
- BUSY = (state != IDLE). All outputs are registered; there is no combinational path from input to output.
- Latency: if START is sampled at edge 0, SE rises after edge 0 and DONE is high in cycle 2N+2, counting the cycle after edge 0 as cycle 1. Total occupancy is 2N+2 cycles.
- START while BUSY is ignored and not queued. START held high re-triggers only at the first IDLE edge after FIN, giving a back-to-back period of 2N+3 cycles.
- PAT and EXP changes during a run have no effect.
- RESP and MISMATCH hold their values until the next run's SHIFT_OUT / FIN respectively.
- Chain convention: SI feeds stage 0, stage k feeds stage k+1, and stage N-1 drives SO. Under this convention, an identity capture returns RESP == PAT.

Decomposition:
- Package scan_ctrl_pkg:
  - state encoding (IDLE=0, SHIFT_IN=1, CAPTURE=2, SHIFT_OUT=3, FIN=4; 3-bit);
  - default CHAIN_LEN constant.
- Sub-module scan_shift_cnt: loadable CNT_W-bit down-counter with load value, decrement enable, and zero flag. It is instantiated once and reused by both shift phases.
- The FSM, the PAT/EXP latches, and the RESP shifter stay in scan_chain_ctrl.

Test Plan:
1. Reset during SHIFT_IN: N=4, START, then RN=0 on the 2nd shift cycle → next cycle SE=0, BUSY=0, RESP=0; no DONE ever appears.
2. Identity loopback: N=4 model chain with capture D=Q; PAT=4'b1011, EXP=4'b1011 → SI sequence 1,0,1,1 with SE=1; CAP high in cycle 5; DONE in cycle 10; RESP=4'b1011; MISMATCH=0.
3. Inverting capture: same chain with capture D=~Q; PAT=4'b1011, EXP=4'b1011 → RESP=4'b0100, MISMATCH=1 at DONE.
4. START ignored while busy: pulse START again at cycle 3 with a different PAT (4'b0001) → still only 4 shift-in cycles carrying 1,0,1,1; exactly one DONE.
5. Back-to-back runs: START held high → second SE rise 2N+3 = 11 cycles after the first. The second run's RESP reflects the second PAT; RESP and MISMATCH from run 1 hold until run 2 overwrites them.
6. Boundary N=1: PAT=1, identity chain → SE high in cycles 1 and 3, CAP in cycle 2, DONE in cycle 4, RESP=1'b1, MISMATCH=0 with EXP=1.

Source files
------------

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared state encoding and default sizing for the scan chain controller.
package scan_ctrl_pkg;

   localparam int unsigned DefChainLen = 8;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StShiftIn  = 3'd1,
      StCapture  = 3'd2,
      StShiftOut = 3'd3,
      StFin      = 3'd4
   } state_e;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host-side handshake between a test-vector source and the scan chain controller.
interface scan_chain_ctrl_if #(
   parameter int unsigned CHAIN_LEN = 8
);
   logic                 START;
   logic [CHAIN_LEN-1:0] PAT;
   logic [CHAIN_LEN-1:0] EXP;
   logic                 BUSY;
   logic                 DONE;
   logic [CHAIN_LEN-1:0] RESP;
   logic                 MISMATCH;

   modport master (
      output START, PAT, EXP,
      input  BUSY, DONE, RESP, MISMATCH
   );

   modport slave (
      input  START, PAT, EXP,
      output BUSY, DONE, RESP, MISMATCH
   );
endinterface

// File: rtl/scan_shift_cnt.sv
// Loadable down-counter shared by the shift-in and shift-out phases.
module scan_shift_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: load pattern, capture once, unload response, compare.
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = DefChainLen,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                C,
   input  logic                RN,
   scan_chain_ctrl_if.slave    host,
   input  logic                SO,
   output logic                SE,
   output logic                SI,
   output logic                CAP
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

   state_e               state_q;
   logic [CHAIN_LEN-1:0] pat_q, exp_q, resp_q;
   logic                 se_q, si_q, cap_q, busy_q, done_q, mis_q;
   logic                 cnt_load, cnt_dec, cnt_zero;
   logic [CHAIN_LEN-1:0] pat_shift, resp_shift;

   // Counter control and shift helpers; shifts are written without part-selects so N=1 works.
   always_comb begin
      cnt_load   = ((state_q == StIdle) && host.START) || (state_q == StCapture);
      cnt_dec    = (state_q == StShiftIn) || (state_q == StShiftOut);
      pat_shift  = pat_q << 1;
      resp_shift = (resp_q << 1) | CHAIN_LEN'(SO);
   end

   scan_shift_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (C),
      .rst_n    (RN),
      .load     (cnt_load),
      .load_val (LastCnt),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Sequencer with registered strobes; the pattern latch doubles as the shift-in register.
   always_ff @(posedge C) begin
      if (!RN) begin
         state_q <= StIdle;
         pat_q   <= '0;
         exp_q   <= '0;
         resp_q  <= '0;
         se_q    <= 1'b0;
         si_q    <= 1'b0;
         cap_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               se_q   <= 1'b0;
               si_q   <= 1'b0;
               cap_q  <= 1'b0;
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (host.START) begin
                  pat_q   <= host.PAT;
                  exp_q   <= host.EXP;
                  se_q    <= 1'b1;
                  si_q    <= host.PAT[CHAIN_LEN-1];
                  busy_q  <= 1'b1;
                  state_q <= StShiftIn;
               end
            end
            StShiftIn: begin
               if (cnt_zero) begin
                  se_q    <= 1'b0;
                  si_q    <= 1'b0;
                  cap_q   <= 1'b1;
                  state_q <= StCapture;
               end else begin
                  pat_q <= pat_shift;
                  si_q  <= pat_shift[CHAIN_LEN-1];
               end
            end
            StCapture: begin
               cap_q   <= 1'b0;
               se_q    <= 1'b1;
               si_q    <= 1'b0;
               state_q <= StShiftOut;
            end
            StShiftOut: begin
               resp_q <= resp_shift;
               if (cnt_zero) begin
                  se_q    <= 1'b0;
                  done_q  <= 1'b1;
                  // Compare the final response so MISMATCH lines up with DONE.
                  mis_q   <= (resp_shift != exp_q);
                  state_q <= StFin;
               end
            end
            StFin: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               se_q    <= 1'b0;
               si_q    <= 1'b0;
               cap_q   <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign SE            = se_q;
   assign SI            = si_q;
   assign CAP           = cap_q;
   assign host.BUSY     = busy_q;
   assign host.DONE     = done_q;
   assign host.RESP     = resp_q;
   assign host.MISMATCH = mis_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: N=4 and N=1 controllers, each driving a behavioural scan chain.
module tb_scan_chain_ctrl;

   logic C = 1'b0;
   logic RN;
   always #5 C = ~C;

   scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus4 ();
   scan_chain_ctrl_if #(.CHAIN_LEN(1)) bus1 ();

   logic so4, se4, si4, cap4;
   logic so1, se1, si1, cap1;

   scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
      .C    (C),
      .RN   (RN),
      .host (bus4.slave),
      .SO   (so4),
      .SE   (se4),
      .SI   (si4),
      .CAP  (cap4)
   );

   scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
      .C    (C),
      .RN   (RN),
      .host (bus1.slave),
      .SO   (so1),
      .SE   (se1),
      .SI   (si1),
      .CAP  (cap1)
   );

   // Behavioural chains: shift when SE, capture D=Q or D=~Q on CAP.
   logic [3:0] chain4 = '0;
   logic       chain1 = 1'b0;
   logic       inv4, inv1;

   always @(posedge C) begin
      if (se4)       chain4 <= {chain4[2:0], si4};
      else if (cap4) chain4 <= inv4 ? ~chain4 : chain4;
      if (se1)       chain1 <= si1;
      else if (cap1) chain1 <= inv1 ? ~chain1 : chain1;
   end
   assign so4 = chain4[3];
   assign so1 = chain1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge C);
      #1;
   endtask

   typedef struct {
      logic [3:0] pat;
      logic [3:0] exp;
      logic       inv;
      logic [3:0] resp;
      logic       mis;
   } vec4_t;

   typedef struct {
      logic pat;
      logic exp;
      logic inv;
      logic resp;
      logic mis;
   } vec1_t;

   vec4_t      vecs4[6];
   vec1_t      vecs1[3];
   logic [3:0] prev_resp;
   logic       prev_mis;

   // Called in cycle 1 of an N=4 run; checks cycles 1..10 and leaves the bench in cycle 10.
   task automatic run4(input string name, input logic [3:0] pat, input logic [3:0] resp,
                       input logic mis, input int stray_cyc);
      for (int c = 1; c <= 10; c++) begin
         logic       se_e, si_e;
         logic [4:0] exp_s;
         se_e  = (c <= 4) || ((c >= 6) && (c <= 9));
         si_e  = (c <= 4) ? pat[4-c] : 1'b0;
         exp_s = {se_e, si_e, (c == 5), (c == 10), 1'b1};
         if ((stray_cyc != 0) && (c == stray_cyc)) begin
            bus4.START = 1'b1;
            bus4.PAT   = 4'b0001;
            bus4.EXP   = 4'b0001;
         end else if ((stray_cyc != 0) && (c == stray_cyc + 1)) begin
            bus4.START = 1'b0;
         end
         check($sformatf("%s c%0d SE/SI/CAP/DONE/BUSY", name, c),
               {se4, si4, cap4, bus4.DONE, bus4.BUSY}, exp_s);
         if (c <= 6) check($sformatf("%s c%0d RESP hold", name, c), bus4.RESP, prev_resp);
         if (c <= 9) check($sformatf("%s c%0d MISMATCH hold", name, c), bus4.MISMATCH, prev_mis);
         if (c == 10) begin
            check($sformatf("%s RESP", name), bus4.RESP, resp);
            check($sformatf("%s MISMATCH", name), bus4.MISMATCH, mis);
         end
         if (c < 10) tick();
      end
      prev_resp = resp;
      prev_mis  = mis;
   endtask

   initial begin
      int done_cnt;
      RN = 1'b0;
      bus4.START = 1'b0; bus4.PAT = '0; bus4.EXP = '0;
      bus1.START = 1'b0; bus1.PAT = '0; bus1.EXP = '0;
      inv4 = 1'b0; inv1 = 1'b0;
      prev_resp = '0; prev_mis = 1'b0;
      tick(); tick();
      check("reset n4 strobes", {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);
      check("reset n4 RESP", bus4.RESP, 4'b0);
      check("reset n4 MISMATCH", bus4.MISMATCH, 1'b0);
      check("reset n1 strobes", {se1, si1, cap1, bus1.DONE, bus1.BUSY}, 5'b0);
      RN = 1'b1;
      tick();

      vecs4[0] = '{pat: 4'b1011, exp: 4'b1011, inv: 1'b0, resp: 4'b1011, mis: 1'b0};
      vecs4[1] = '{pat: 4'b1011, exp: 4'b1011, inv: 1'b1, resp: 4'b0100, mis: 1'b1};
      vecs4[2] = '{pat: 4'b0000, exp: 4'b0001, inv: 1'b0, resp: 4'b0000, mis: 1'b1};
      vecs4[3] = '{pat: 4'b1111, exp: 4'b0000, inv: 1'b1, resp: 4'b0000, mis: 1'b0};
      vecs4[4] = '{pat: 4'b0110, exp: 4'b0110, inv: 1'b0, resp: 4'b0110, mis: 1'b0};
      vecs4[5] = '{pat: 4'b1001, exp: 4'b1001, inv: 1'b1, resp: 4'b0110, mis: 1'b1};
      vecs1[0] = '{pat: 1'b1, exp: 1'b1, inv: 1'b0, resp: 1'b1, mis: 1'b0};
      vecs1[1] = '{pat: 1'b1, exp: 1'b1, inv: 1'b1, resp: 1'b0, mis: 1'b1};
      vecs1[2] = '{pat: 1'b0, exp: 1'b1, inv: 1'b0, resp: 1'b0, mis: 1'b1};

      for (int i = 0; i < 6; i++) begin
         inv4 = vecs4[i].inv;
         bus4.PAT = vecs4[i].pat; bus4.EXP = vecs4[i].exp; bus4.START = 1'b1;
         tick();
         bus4.START = 1'b0;
         run4($sformatf("vec%0d", i), vecs4[i].pat, vecs4[i].resp, vecs4[i].mis, 0);
         tick();
         check($sformatf("vec%0d idle", i), {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);
      end

      // START while busy with a different pattern must be dropped.
      inv4 = 1'b0;
      bus4.PAT = 4'b1011; bus4.EXP = 4'b1011; bus4.START = 1'b1;
      tick();
      bus4.START = 1'b0;
      run4("busy", 4'b1011, 4'b1011, 1'b0, 3);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("busy after c%0d", k), {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);
      end

      // START held high: PAT/EXP changed mid-run only affect the second run.
      bus4.PAT = 4'b1011; bus4.EXP = 4'b1011; bus4.START = 1'b1;
      tick();
      bus4.PAT = 4'b0110; bus4.EXP = 4'b0111;
      run4("b2b run1", 4'b1011, 4'b1011, 1'b0, 0);
      tick();
      check("b2b gap strobes", {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);
      check("b2b gap RESP", bus4.RESP, 4'b1011);
      check("b2b gap MISMATCH", bus4.MISMATCH, 1'b0);
      tick();
      bus4.START = 1'b0;
      run4("b2b run2", 4'b0110, 4'b0110, 1'b1, 0);
      tick();
      check("b2b idle", {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);

      // Reset on the second shift-in cycle aborts the run with no DONE.
      bus4.PAT = 4'b1011; bus4.EXP = 4'b1011; bus4.START = 1'b1;
      tick();
      bus4.START = 1'b0;
      tick();
      check("midrst c2 SE", se4, 1'b1);
      RN = 1'b0;
      tick();
      check("midrst strobes", {se4, si4, cap4, bus4.DONE, bus4.BUSY}, 5'b0);
      check("midrst RESP", bus4.RESP, 4'b0);
      check("midrst MISMATCH", bus4.MISMATCH, 1'b0);
      RN = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus4.DONE === 1'b1) done_cnt++;
      end
      check("midrst no DONE", done_cnt, 0);
      check("midrst BUSY", bus4.BUSY, 1'b0);

      // N=1: SE in cycles 1 and 3, CAP in 2, DONE in 4.
      for (int i = 0; i < 3; i++) begin
         inv1 = vecs1[i].inv;
         bus1.PAT = vecs1[i].pat; bus1.EXP = vecs1[i].exp; bus1.START = 1'b1;
         tick();
         bus1.START = 1'b0;
         for (int c = 1; c <= 4; c++) begin
            logic [4:0] exp_s;
            unique case (c)
               1:       exp_s = {1'b1, vecs1[i].pat, 3'b001};
               2:       exp_s = 5'b00101;
               3:       exp_s = 5'b10001;
               default: exp_s = 5'b00011;
            endcase
            check($sformatf("n1 vec%0d c%0d SE/SI/CAP/DONE/BUSY", i, c),
                  {se1, si1, cap1, bus1.DONE, bus1.BUSY}, exp_s);
            if (c < 4) tick();
         end
         check($sformatf("n1 vec%0d RESP", i), bus1.RESP, vecs1[i].resp);
         check($sformatf("n1 vec%0d MISMATCH", i), bus1.MISMATCH, vecs1[i].mis);
         tick();
         check($sformatf("n1 vec%0d idle", i), {se1, si1, cap1, bus1.DONE, bus1.BUSY}, 5'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
